// File: rtl/mem_stage.sv
// MEM pipeline stage: serialises byte/halfword/word loads and stores onto a byte-wide req/gnt bus.
// Optional MEM_ALIGN_CHECK_EN: misaligned halfword/word ops fault without a bus transfer and pulse misalign_o.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  aluop_i,
    input  logic        inquiry_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_dout_o,
    input  logic [7:0]  mem_din_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic [1:0]  dbg_state_o
);
    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                           OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t      state;
    logic        last_inq;
    logic [2:0]  k;
    logic [31:0] result;
    logic        rd_pend;
    logic [1:0]  rd_lane;
    logic        fault;

    logic        is_load, is_store, new_op, bad_align;
    logic [2:0]  n_bytes, k_next;
    logic [31:0] store_sh, load_ext;

    always_comb begin
        is_load  = (aluop_i >= OP_LB) && (aluop_i <= OP_LHU);
        is_store = (aluop_i >= OP_SB) && (aluop_i <= OP_SW);
        new_op   = (is_load || is_store) && (inquiry_i != last_inq);
        k_next   = k + 3'd1;
        store_sh = wdata_i >> {k_next[1:0], 3'b000};
        case (aluop_i)
            OP_LH, OP_LHU, OP_SH: n_bytes = 3'd2;
            OP_LW, OP_SW:         n_bytes = 3'd4;
            default:              n_bytes = 3'd1;
        endcase
        case (aluop_i)
            OP_LB:   load_ext = {{24{result[7]}}, result[7:0]};
            OP_LBU:  load_ext = {24'd0, result[7:0]};
            OP_LH:   load_ext = {{16{result[15]}}, result[15:0]};
            OP_LHU:  load_ext = {16'd0, result[15:0]};
            default: load_ext = result;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_align  = ((n_bytes == 3'd2) && mem_addr_i[0]) ||
                        ((n_bytes == 3'd4) && (mem_addr_i[1:0] != 2'b00));
    assign misalign_o = (state == DONE) && fault;
`else
    assign bad_align  = 1'b0;
`endif

    // Bus handshake: a byte moves on every rising edge where mem_req_o and mem_gnt_i are both high;
    // address/data/we stay fixed until granted, and read data arrives on mem_din_i one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_inq   <= 1'b0;
            k          <= 3'd0;
            result     <= 32'd0;
            rd_pend    <= 1'b0;
            rd_lane    <= 2'd0;
            fault      <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_a_o    <= 32'd0;
            mem_dout_o <= 8'd0;
        end else begin
            if (rd_pend) begin
                result[{rd_lane, 3'b000} +: 8] <= mem_din_i;
                rd_pend <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (new_op) begin
                        last_inq <= inquiry_i;
                        k        <= 3'd0;
                        result   <= 32'd0;
                        fault    <= bad_align;
                        if (bad_align) begin
                            state <= DONE;
                        end else begin
                            state      <= XFER;
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= is_store;
                            mem_a_o    <= mem_addr_i;
                            mem_dout_o <= is_store ? wdata_i[7:0] : 8'd0;
                        end
                    end
                end
                XFER: begin
                    if (mem_gnt_i) begin
                        if (!is_store) begin
                            rd_pend <= 1'b1;
                            rd_lane <= k[1:0];
                        end
                        if (k_next == n_bytes) begin
                            k          <= 3'd0;
                            mem_req_o  <= 1'b0;
                            mem_we_o   <= 1'b0;
                            mem_a_o    <= 32'd0;
                            mem_dout_o <= 8'd0;
                            state      <= is_store ? DONE : DRAIN;
                        end else begin
                            k          <= k_next;
                            mem_a_o    <= mem_addr_i + {29'd0, k_next};
                            mem_dout_o <= is_store ? store_sh[7:0] : 8'd0;
                        end
                    end
                end
                DRAIN:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Held load results keep being presented while EX/MEM is frozen by another stage.
    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_req_o = 1'b0;
        if (rst) begin
            wd_o    = 5'd0;
            wreg_o  = 1'b0;
            wdata_o = 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_op) begin
                        stall_req_o = 1'b1;
                        wreg_o      = 1'b0;
                    end else if (is_load) begin
                        wdata_o = load_ext;
                        wreg_o  = wreg_i & ~fault;
                    end else if (is_store) begin
                        wreg_o = 1'b0;
                    end
                end
                XFER, DRAIN: begin
                    stall_req_o = 1'b1;
                    wreg_o      = 1'b0;
                end
                default: begin
                    wreg_o = wreg_i & is_load & ~fault;
                    if (is_load) wdata_o = load_ext;
                end
            endcase
        end
    end

    assign dbg_state_o = state;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-bus responder with a memory model, op driver and result scoreboard.
// Covers pass-through, loads/stores with stalled grants, held results, mid-op reset and address wrap.
`timescale 1ns/1ps
module tb_mem_stage;
    localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                           OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, mem_addr_i;
    logic [3:0]  aluop_i;
    logic        inquiry_i;
    logic        mem_req_o, mem_gnt_i, mem_we_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o, mem_din_i;
    logic [4:0]  wd_o;
    logic        wreg_o, stall_req_o;
    logic [31:0] wdata_o;
    logic [1:0]  dbg_state_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .mem_addr_i  (mem_addr_i),
        .aluop_i     (aluop_i),
        .inquiry_i   (inquiry_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_we_o    (mem_we_o),
        .mem_a_o     (mem_a_o),
        .mem_dout_o  (mem_dout_o),
        .mem_din_i   (mem_din_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_o  (misalign_o),
`endif
        .dbg_state_o (dbg_state_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int          n_checks = 0;
    int          n_pass = 0;
    logic [37:0] exp_q[$];   // {wd, wreg, wdata}
    logic [40:0] bus_q[$];   // {we, addr, data}
    logic [7:0]  mem_model[logic [31:0]];
    int          deny_left = 0;
    bit          rand_gnt = 1'b0;
    int          req_cycles = 0;
    int          gnt_count = 0;
    logic        inq_model = 1'b0;
    bit          rd_pend_tb = 1'b0;
    logic [31:0] rd_addr_tb = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 8'h00;
    endfunction

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 1;
        endcase
    endfunction

    // byte-bus responder: grant decided mid-cycle, read data returned the following cycle
    initial begin
        mem_gnt_i = 1'b0;
        mem_din_i = 8'h00;
        forever begin
            @(negedge clk);
            mem_din_i  = rd_pend_tb ? rd_byte(rd_addr_tb) : 8'($urandom_range(0, 255));
            rd_pend_tb = 1'b0;
            if (mem_req_o) begin
                req_cycles++;
                if (deny_left > 0) begin
                    mem_gnt_i = 1'b0;
                    deny_left--;
                end else begin
                    mem_gnt_i = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (mem_gnt_i) begin
                    logic [40:0] e;
                    gnt_count++;
                    if (bus_q.size() == 0) begin
                        check("bus_unexpected_xfer", 32'(bus_q.size()), 32'd1);
                    end else begin
                        e = bus_q.pop_front();
                        check("bus_we", 32'(mem_we_o), 32'(e[40]));
                        check("bus_addr", mem_a_o, e[39:8]);
                        if (e[40]) begin
                            check("bus_wdata", 32'(mem_dout_o), 32'(e[7:0]));
                        end else begin
                            rd_pend_tb = 1'b1;
                            rd_addr_tb = mem_a_o;
                        end
                    end
                end
            end else begin
                mem_gnt_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // builds expectations from the memory model and launches one op (call at negedge+1, FSM idle)
    task automatic start_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] wd, input logic wreg, input int deny);
        int          n;
        bit          ld;
        logic [31:0] v, a;
        n  = op_bytes(op);
        ld = (op <= OP_LHU);
        v  = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if (ld) begin
                bus_q.push_back({1'b0, a, 8'h00});
                v[8*i +: 8] = rd_byte(a);
            end else begin
                bus_q.push_back({1'b1, a, data[8*i +: 8]});
                mem_model[a] = data[8*i +: 8];
            end
        end
        case (op)
            OP_LB:   v = {{24{v[7]}}, v[7:0]};
            OP_LH:   v = {{16{v[15]}}, v[15:0]};
            default: v = v;
        endcase
        exp_q.push_back({wd, ld ? wreg : 1'b0, v});
        deny_left  = deny;
        req_cycles = 0;
        wd_i       = wd;
        wreg_i     = wreg;
        wdata_i    = data;
        mem_addr_i = addr;
        aluop_i    = op;
        inq_model  = ~inq_model;
        inquiry_i  = inq_model;
        #1;
        check("detect_stall", 32'(stall_req_o), 32'd1);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] wd, input logic wreg, input int deny);
        int          stall_cycles;
        int          n;
        bit          ld;
        logic [37:0] e;
        n  = op_bytes(op);
        ld = (op <= OP_LHU);
        start_op(op, addr, data, wd, wreg, deny);
        stall_cycles = 0;
        repeat (200) begin
            @(negedge clk); #1;
            if (!stall_req_o) break;
            stall_cycles++;
        end
        check("stall_drop", 32'(stall_req_o), 32'd0);
        e = exp_q.pop_front();
        if (ld) check("done_wdata", wdata_o, e[31:0]);
        check("done_wreg", 32'(wreg_o), 32'(e[32]));
        check("done_wd", 32'(wd_o), 32'(e[37:33]));
        check("done_req_low", 32'(mem_req_o), 32'd0);
        check("bus_q_left", 32'(bus_q.size()), 32'd0);
        if (!rand_gnt) begin
            check("stall_cycles", 32'(stall_cycles), 32'(n + int'(ld) + deny));
            check("req_cycles", 32'(req_cycles), 32'(n + deny));
        end
        @(negedge clk); #1;
    endtask

    initial begin
        logic [3:0] op;
        logic [31:0] addr;
        int g0;

        // reset with non-zero NOP inputs
        rst = 1'b1; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hCAFEF00D;
        mem_addr_i = 32'd0; aluop_i = OP_NOP; inquiry_i = 1'b0; inq_model = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wd", 32'(wd_o), 32'd0);
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_stall", 32'(stall_req_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", mem_a_o, 32'd0);
        check("rst_dout", 32'(mem_dout_o), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        rst = 1'b0;
        #1;
        check("nop_wd", 32'(wd_o), 32'd9);
        check("nop_wreg", 32'(wreg_o), 32'd1);
        check("nop_wdata", wdata_o, 32'hCAFEF00D);

        // NOP codes pass through even when inquiry flips
        foreach (mem_model[i]) mem_model.delete(i);
        for (int i = 0; i < 3; i++) begin
            aluop_i   = (i == 0) ? OP_NOP : ((i == 1) ? 4'd9 : 4'd15);
            wdata_i   = $urandom;
            inquiry_i = ~inq_model;
            #1;
            check("nop_stall", 32'(stall_req_o), 32'd0);
            check("nop_pass", wdata_o, wdata_i);
            @(negedge clk); #1;
            check("nop_no_req", 32'(mem_req_o), 32'd0);
        end
        inquiry_i = inq_model;
        @(negedge clk); #1;

        // LW 0x100, grant always high
        mem_model[32'h100] = 8'h11; mem_model[32'h101] = 8'h22;
        mem_model[32'h102] = 8'h33; mem_model[32'h103] = 8'h44;
        run_op(OP_LW, 32'h100, 32'h0, 5'd4, 1'b1, 0);

        // same inquiry held: no new request, result held
        for (int i = 0; i < 3; i++) begin
            check("hold_req", 32'(mem_req_o), 32'd0);
            check("hold_stall", 32'(stall_req_o), 32'd0);
            check("hold_wdata", wdata_o, 32'h44332211);
            @(negedge clk); #1;
        end

        // sign / zero extension
        mem_model[32'h7] = 8'h80;
        run_op(OP_LB, 32'h7, 32'h0, 5'd5, 1'b1, 0);
        run_op(OP_LBU, 32'h7, 32'h0, 5'd6, 1'b1, 0);

        // SH with grant withheld for the first two request cycles
        run_op(OP_SH, 32'h20, 32'hDEADBEEF, 5'd7, 1'b1, 2);
        run_op(OP_LH, 32'h20, 32'h0, 5'd8, 1'b1, 0);
        run_op(OP_LHU, 32'h20, 32'h0, 5'd8, 1'b1, 1);
        run_op(OP_SB, 32'h41, 32'h12345678, 5'd2, 1'b1, 0);
        run_op(OP_SW, 32'h44, 32'h8899AABB, 5'd3, 1'b1, 0);
        run_op(OP_LW, 32'h44, 32'h0, 5'd3, 1'b0, 0);

`ifdef MEM_ALIGN_CHECK_EN
        // misaligned word faults without touching the bus
        req_cycles = 0;
        aluop_i = OP_LW; mem_addr_i = 32'h102; wreg_i = 1'b1; wd_i = 5'd1;
        inq_model = ~inq_model; inquiry_i = inq_model;
        #1;
        check("mis_detect_stall", 32'(stall_req_o), 32'd1);
        @(negedge clk); #1;
        check("mis_pulse", 32'(misalign_o), 32'd1);
        check("mis_wreg", 32'(wreg_o), 32'd0);
        check("mis_stall", 32'(stall_req_o), 32'd0);
        @(negedge clk); #1;
        check("mis_pulse_end", 32'(misalign_o), 32'd0);
        check("mis_req_cycles", 32'(req_cycles), 32'd0);
`else
        // misaligned and wrapping accesses go bytewise
        run_op(OP_LW, 32'h102, 32'h0, 5'd1, 1'b1, 0);
        run_op(OP_SW, 32'hFFFFFFFE, 32'h01020304, 5'd1, 1'b1, 0);
        run_op(OP_LW, 32'hFFFFFFFE, 32'h0, 5'd1, 1'b1, 0);
`endif

        // random ops with random grant
        rand_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op   = 4'($urandom_range(1, 8));
            addr = 32'h300 + 32'($urandom_range(0, 31));
`ifdef MEM_ALIGN_CHECK_EN
            if (op_bytes(op) == 2) addr[0] = 1'b0;
            if (op_bytes(op) == 4) addr[1:0] = 2'b00;
`endif
            run_op(op, addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0);
        end
        rand_gnt = 1'b0;

        // reset asserted after two bytes of a word load
        mem_model[32'h200] = 8'hA1; mem_model[32'h201] = 8'hB2;
        mem_model[32'h202] = 8'hC3; mem_model[32'h203] = 8'hD4;
        g0 = gnt_count;
        start_op(OP_LW, 32'h200, 32'h0, 5'd3, 1'b1, 0);
        repeat (20) begin
            @(negedge clk); #1;
            if (gnt_count - g0 >= 2) break;
        end
        check("mid_grants", 32'(gnt_count - g0), 32'd2);
        rst = 1'b1;
        @(negedge clk); #1;
        check("abort_req", 32'(mem_req_o), 32'd0);
        check("abort_stall", 32'(stall_req_o), 32'd0);
        check("abort_state", 32'(dbg_state_o), 32'd0);
        void'(exp_q.pop_back());
        bus_q.delete();
        inq_model = 1'b0;
        inquiry_i = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_no_partial", wdata_o, 32'd0);
        check("abort_idle_stall", 32'(stall_req_o), 32'd0);
        @(negedge clk); #1;
        check("abort_idle_req", 32'(mem_req_o), 32'd0);
        run_op(OP_LW, 32'h200, 32'h0, 5'd3, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
